mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, beside the single-cycle ALU.
- Takes MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO operations from ID/EX and holds the architectural HI/LO registers.
- Runs each operation as an iterative 32-step shift-add or restoring-divide loop.
- Raises busy so the hazard unit stalls MFHI/MFLO and any further MDU ops until the result is committed.

Parameters:
WIDTH, 32, operand/HI/LO width; ITERS = WIDTH iterations per mult/div

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  issue strobe; accepted only when busy=0
operation  input  3  MDU op code (`MDU_MULT, `MDU_MULTU, `MDU_DIV, `MDU_DIVU, `MDU_MTHI, `MDU_MTLO)
inputA  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
inputB  input  WIDTH  rt operand (multiplier / divisor)
busy  output  1  operation in flight; stall request to hazard unit
done  output  1  one-cycle pulse: HI/LO hold the new result this cycle
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (rst_n=0 at an edge): busy=0, done=0, hi=0, lo=0, iteration counter=0, FSM=IDLE. Applies mid-operation: the in-flight op is abandoned, no done pulse.
- FSM states:
  - IDLE -> RUN on start with a mult/div op.
  - RUN -> IDLE after the ITERS-th iteration edge.
  - IDLE -> IDLE for MTHI/MTLO.
- Accept: start=1 and busy=0 at edge E0 latches operands and op. Signed ops latch absolute values plus result-sign and remainder-sign flags.
- Latency: busy=1 in the cycles after E0 through E32 (exactly 32 cycles). Iterations occur on edges E1..E32. At E32 hi/lo are written with sign correction applied, busy drops, and done=1 for the single cycle after E32.
- MULT/MULTU: {hi,lo} = full 64-bit product, signed or unsigned.
- DIV/DIVU: lo = quotient, hi = remainder. Quotient truncates toward zero; remainder takes the sign of the dividend.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap, no trap).
- Divide by zero (inputB=0, DIV or DIVU):
  - No iterations.
  - At E1: lo=0xFFFFFFFF, hi=inputA, done=1 in the cycle after E1.
  - busy high one cycle.
- MTHI/MTLO: when busy=0, hi (resp. lo) = inputA at E0. No busy, no done. The other register is unchanged.
- start while busy=1 is ignored entirely (no latch, no register change). The hazard unit guarantees it is not issued.
- Undefined op code with start: ignored, FSM stays IDLE.
- hi/lo never change during RUN; partial results live in internal shadow registers only.

Optional Feature:
- Macro: MDU_FAST_MUL_EN
- Defined: MULT/MULTU compute the 64-bit product combinationally at E0's next edge (E1). busy is high for 1 cycle and done pulses the cycle after E1. DIV/DIVU are unchanged (32 cycles).
- Undefined: multiplies use the iterative 32-cycle path described above.

Decomposition:
- define.vh holds:
  - `MDU_MULT=3'd0, `MDU_MULTU=3'd1, `MDU_DIV=3'd2, `MDU_DIVU=3'd3, `MDU_MTHI=3'd4, `MDU_MTLO=3'd5
  - FSM state encodings `MDU_IDLE, `MDU_RUN
- Sub-module mdu_iter_step: combinational single-iteration datapath. Inputs are accumulator, shift register, operand and mode. Outputs are next accumulator and shift register (add-shift for mult, trial-subtract-shift for div).
- The top holds the FSM, counter, sign fix-up and HI/LO.

Test Plan:
- MULT inputA=0xFFFFFFFE, inputB=3 -> busy high 32 cycles, then done, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. With MDU_FAST_MUL_EN: same values, busy 1 cycle.
- DIV -7 (0xFFFFFFF9) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234/0 -> busy 1 cycle, lo=0xFFFFFFFF, hi=0x00001234.
- MTHI 0xDEADBEEF, then MTLO 0x12345678 on consecutive cycles -> hi=0xDEADBEEF, lo=0x12345678, busy/done stay 0. During a running DIV, an MTLO start pulse -> lo unchanged until the DIV result.
- Start MULT 5*6, pulse rst_n=0 at iteration 10 -> busy=0, hi=lo=0, no done. A new MULT 5*6 afterwards -> lo=30, hi=0.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// +----------------------------------------------------------------------+
// | mul_div_unit_pkg                                                     |
// | Shared op codes and FSM state type for the multiply/divide unit.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package mul_div_unit_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [0:0] {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

endpackage

`default_nettype wire

// File: rtl/mdu_iter_step.sv
// +----------------------------------------------------------------------+
// | mdu_iter_step                                                        |
// | One combinational iteration of the MDU datapath.                     |
// |   mult: shift-add, {acc,sr} >> 1 after adding opnd when sr[0]=1      |
// |   div : restoring trial-subtract, quotient bit shifted into sr       |
// | Ports: acc, sr, opnd (in), div_mode (in), acc_next, sr_next (out)    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mdu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] sr,
  input  logic [WIDTH-1:0] opnd,
  input  logic             div_mode,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] sr_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum      = {1'b0, acc} + (sr[0] ? {1'b0, opnd} : '0);
    shifted  = {acc, sr[WIDTH-1]};
    diff     = shifted - {1'b0, opnd};
    acc_next = sum[WIDTH:1];
    sr_next  = {sum[0], sr[WIDTH-1:1]};
    if (div_mode) begin
      // Remainder is always below the divisor, so the top bit of diff is a
      // clean borrow flag.
      if (!diff[WIDTH]) begin
        acc_next = diff[WIDTH-1:0];
        sr_next  = {sr[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = shifted[WIDTH-1:0];
        sr_next  = {sr[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// +----------------------------------------------------------------------+
// | mul_div_unit                                                         |
// | Multi-cycle MIPS multiply/divide unit holding HI/LO.                 |
// | Ports: clk, rst_n (sync, active low), start, operation[2:0],         |
// |        inputA, inputB (operands); busy, done, hi, lo (outputs).      |
// | Optional macro MDU_FAST_MUL_EN: single-cycle MULT/MULTU.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int ITERS = WIDTH;
  localparam int CW    = $clog2(ITERS);

  mdu_state_e       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, sr, opnd;
  logic             is_div, div_zero, neg_res, neg_rem;
  logic [WIDTH-1:0] acc_next, sr_next;

  // Operand decode for the accept edge.
  logic             op_mult, op_div, op_signed, a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;

  always_comb begin
    op_mult   = (operation == MDU_MULT) || (operation == MDU_MULTU);
    op_div    = (operation == MDU_DIV)  || (operation == MDU_DIVU);
    op_signed = (operation == MDU_MULT) || (operation == MDU_DIV);
    a_neg     = op_signed && inputA[WIDTH-1];
    b_neg     = op_signed && inputB[WIDTH-1];
    abs_a     = a_neg ? -inputA : inputA;
    abs_b     = b_neg ? -inputB : inputB;
  end

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .sr       (sr),
    .opnd     (opnd),
    .div_mode (is_div),
    .acc_next (acc_next),
    .sr_next  (sr_next)
  );

  // Sign fix-up applied to the final iteration's outputs so the result
  // can be committed on the same edge as the last step.
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    prod_raw = {acc_next, sr_next};
    prod_fix = neg_res ? -prod_raw : prod_raw;
    quot_fix = neg_res ? -sr_next  : sr_next;
    rem_fix  = neg_rem ? -acc_next : acc_next;
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_raw, fast_fix;
  always_comb begin
    fast_raw = {{WIDTH{1'b0}}, opnd} * {{WIDTH{1'b0}}, sr};
    fast_fix = neg_res ? -fast_raw : fast_raw;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= MDU_IDLE;
      cnt      <= '0;
      acc      <= '0;
      sr       <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MDU_IDLE: begin
          if (start && (op_mult || op_div)) begin
            state    <= MDU_RUN;
            busy     <= 1'b1;
            cnt      <= '0;
            acc      <= '0;
            is_div   <= op_div;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= op_div && (inputB == '0);
            sr       <= op_div ? abs_a : abs_b;
            // A zero divisor needs the raw dividend for HI, and opnd is
            // otherwise unused on that path.
            opnd     <= op_div ? ((inputB == '0) ? inputA : abs_b) : abs_a;
          end else if (start && (operation == MDU_MTHI)) begin
            hi <= inputA;
          end else if (start && (operation == MDU_MTLO)) begin
            lo <= inputA;
          end
        end
        MDU_RUN: begin
          if (div_zero) begin
            lo    <= '1;
            hi    <= opnd;
            state <= MDU_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
`ifdef MDU_FAST_MUL_EN
          end else if (!is_div) begin
            {hi, lo} <= fast_fix;
            state    <= MDU_IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
`endif
          end else begin
            acc <= acc_next;
            sr  <= sr_next;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(ITERS - 1)) begin
              if (is_div) begin
                lo <= quot_fix;
                hi <= rem_fix;
              end else begin
                {hi, lo} <= prod_fix;
              end
              state <= MDU_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// +----------------------------------------------------------------------+
// | tb_mul_div_unit                                                      |
// | Self-checking bench for mul_div_unit against an arithmetic model.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mul_div_unit;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 32;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  operation = 3'd0;
  logic [31:0] inputA = '0;
  logic [31:0] inputB = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  // Architectural HI/LO as the model sees them.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .operation (operation),
    .inputA    (inputA),
    .inputB    (inputB),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  // Reference: plain arithmetic on the architectural meaning of each op.
  task automatic model(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int lat);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lat = 0;
    case (op)
      OP_MULT:  begin p = 64'(sa * sb); {m_hi, m_lo} = p; lat = MUL_LAT; end
      OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; lat = MUL_LAT; end
      OP_DIV, OP_DIVU: begin
        if (b == 0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = a; lat = 1;
        end else begin
          if (op == OP_DIV) begin sq = sa / sb; sr = sa % sb; end
          else begin sq = longint'(a) / longint'(b); sr = longint'(a) % longint'(b); end
          m_lo = sq[31:0]; m_hi = sr[31:0]; lat = 32;
        end
      end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  // Drives one op and measures the busy window; comparisons live in tests.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output bit done_end, output bit stable,
                       output bit early_done);
    logic [31:0] h0, l0;
    @(negedge clk);
    start = 1'b1; operation = op; inputA = a; inputB = b;
    @(posedge clk); #1;
    start = 1'b0;
    h0 = hi; l0 = lo; lat = 0; stable = 1'b1; early_done = 1'b0;
    while (busy && lat < 100) begin
      if (done) early_done = 1'b1;
      if (hi !== h0 || lo !== l0) stable = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    done_end = done;
  endtask

  // Runs one op through DUT and model and compares everything observable.
  task automatic check_op(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    int lat, exp_lat;
    bit d, st, ed;
    model(op, a, b, exp_lat);
    issue(op, a, b, lat, d, st, ed);
    checks++;
    if (lat !== exp_lat) begin errors++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, exp_lat); end
    checks++;
    if (d !== (exp_lat > 0)) begin errors++; $display("FAIL %s done_pulse got=%0b exp=%0b", name, d, exp_lat > 0); end
    checks++;
    if (!st || ed) begin errors++; $display("FAIL %s hilo_stable_during_run got stable=%0b early_done=%0b exp stable=1 early_done=0", name, st, ed); end
    checks++;
    if (hi !== m_hi) begin errors++; $display("FAIL %s hi got=%h exp=%h", name, hi, m_hi); end
    checks++;
    if (lo !== m_lo) begin errors++; $display("FAIL %s lo got=%h exp=%h", name, lo, m_lo); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, hi, lo} !== 66'b0) begin
      errors++; $display("FAIL reset busy=%b done=%b hi=%h lo=%h exp all zero", busy, done, hi, lo);
    end
    @(negedge clk); rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_mult();
    check_op("mult_neg2x3", OP_MULT, 32'hFFFF_FFFE, 32'd3);
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
      errors++; $display("FAIL mult_const got=%h%h exp=FFFFFFFFFFFFFFFA", hi, lo);
    end
    check_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      errors++; $display("FAIL multu_const got=%h%h exp=FFFFFFFE00000001", hi, lo);
    end
  endtask

  task automatic test_div();
    check_op("div_neg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div_const got hi=%h lo=%h exp hi=FFFFFFFF lo=FFFFFFFD", hi, lo);
    end
    check_op("divu_7by2", OP_DIVU, 32'd7, 32'd2);
    check_op("div_minint_by_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    checks++;
    if (lo !== 32'h8000_0000 || hi !== 32'h0) begin
      errors++; $display("FAIL div_wrap got hi=%h lo=%h exp hi=00000000 lo=80000000", hi, lo);
    end
  endtask

  task automatic test_divzero();
    check_op("divu_by0", OP_DIVU, 32'h1234, 32'd0);
    check_op("div_by0", OP_DIV, 32'h8765_4321, 32'd0);
  endtask

  task automatic test_mthi_mtlo();
    int lat;
    // Back-to-back moves: second start on the very next edge.
    @(negedge clk);
    start = 1'b1; operation = OP_MTHI; inputA = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mthi_flags busy=%b done=%b exp 0 0", busy, done); end
    operation = OP_MTLO; inputA = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    model(OP_MTHI, 32'hDEAD_BEEF, 0, lat);
    model(OP_MTLO, 32'h1234_5678, 0, lat);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mtlo_flags busy=%b done=%b exp 0 0", busy, done); end
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      errors++; $display("FAIL mthi_mtlo got hi=%h lo=%h exp hi=%h lo=%h", hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_mtlo_during_div();
    int lat, n;
    model(OP_DIVU, 32'd1000, 32'd7, lat);
    @(negedge clk);
    start = 1'b1; operation = OP_DIVU; inputA = 32'd1000; inputB = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; operation = OP_MTLO; inputA = 32'hAAAA_5555;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!done) begin errors++; $display("FAIL mtlo_in_div timeout done=%b exp 1", done); end
    checks++;
    if (lo !== m_lo || hi !== m_hi) begin
      errors++; $display("FAIL mtlo_in_div got hi=%h lo=%h exp hi=%h lo=%h", hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_undefined_op();
    int lat, exp_lat;
    bit d, st, ed;
    model(3'd6, 32'h5555_5555, 32'd9, exp_lat);
    issue(3'd6, 32'h5555_5555, 32'd9, lat, d, st, ed);
    checks++;
    if (lat != 0 || d !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL undef_op got lat=%0d done=%b busy=%b exp 0 0 0", lat, d, busy);
    end
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      errors++; $display("FAIL undef_op_hilo got hi=%h lo=%h exp hi=%h lo=%h", hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_abort_reset();
    bit saw_done;
    @(negedge clk);
    start = 1'b1; operation = OP_MULT; inputA = 32'd5; inputB = 32'd6;
    @(negedge clk);
    start = 1'b0;
    saw_done = 1'b0;
    repeat (10) begin if (done) saw_done = 1'b1; @(negedge clk); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    checks++;
    if ({busy, done, hi, lo} !== 66'b0) begin
      errors++; $display("FAIL abort_reset busy=%b done=%b hi=%h lo=%h exp all zero", busy, done, hi, lo);
    end
    repeat (40) begin if (done) saw_done = 1'b1; @(negedge clk); end
    checks++;
    if (saw_done) begin errors++; $display("FAIL abort_no_done got done=1 exp 0"); end
    check_op("mult_after_abort", OP_MULT, 32'd5, 32'd6);
    checks++;
    if (lo !== 32'd30 || hi !== 32'd0) begin
      errors++; $display("FAIL mult_after_abort_const got hi=%h lo=%h exp 0 1e", hi, lo);
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 5));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      check_op("random", op, a, b);
    end
  endtask

  task automatic test_back_to_back();
    check_op("b2b_div", OP_DIV, 32'd100, 32'hFFFF_FFFD);
    check_op("b2b_mult", OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000);
    check_op("b2b_divz", OP_DIVU, 32'hCAFE, 32'd0);
    check_op("b2b_mthi", OP_MTHI, 32'h0BAD_F00D, 32'd0);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_divzero();
    test_mthi_mtlo();
    test_mtlo_during_div();
    test_undefined_op();
    test_abort_reset();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
